// File: rtl/t03_pkg.sv
// t03_pkg: shared types and constants for the t03 fetch stage
package t03_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, VALID, FLUSH} fetch_state_t;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/t03_fetch_if.sv
// t03_fetch_if: fetch-stage bundle covering imem, redirect and decoder handshakes
interface t03_fetch_if;
  logic        en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        inst_ready;
  modport master (
    input  en, imem_ack, imem_rdata, redirect_valid, redirect_target, inst_ready,
    output imem_req, imem_addr, inst, inst_pc, pc_plus4, inst_valid
  );
  modport slave (
    output en, imem_ack, imem_rdata, redirect_valid, redirect_target, inst_ready,
    input  imem_req, imem_addr, inst, inst_pc, pc_plus4, inst_valid
  );
endinterface

// File: rtl/t03_pc_reg.sv
// t03_pc_reg: program counter with load/increment/hold
module t03_pc_reg #(
  parameter logic [31:0] RESET_PC = t03_pkg::RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_incr,
  input  logic [31:0] i_target,
  output logic [31:0] o_pc
);
  logic [31:0] r_pc;
  // load wins over increment; otherwise hold
  always_ff @(posedge clk)
    r_pc <= rst ? RESET_PC : i_load ? i_target : i_incr ? r_pc + 32'd4 : r_pc;
  assign o_pc = r_pc;
endmodule

// File: rtl/t03_fetch.sv
// t03_fetch: PC, imem request FSM and instruction register feeding the decoder
module t03_fetch #(
  parameter logic [31:0] RESET_PC = t03_pkg::RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = t03_pkg::NOP_INST_DEF
) (
  input logic         clk,
  input logic         rst,
  t03_fetch_if.master bus
);
  import t03_pkg::*;
  fetch_state_t r_state, w_next;
  logic [31:0] r_addr, r_inst, w_pc, w_target, w_addr_d;
  logic        w_pc_incr, w_addr_load, w_inst_load, w_inst_clr;
  assign w_target  = word_align(bus.redirect_target);
  assign w_addr_d  = bus.redirect_valid ? w_target : r_state == VALID ? w_pc + 32'd4 : w_pc;
  assign w_pc_incr = r_state == VALID && !bus.redirect_valid && bus.inst_ready;
  t03_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .i_load   (bus.redirect_valid),
    .i_incr   (w_pc_incr),
    .i_target (w_target),
    .o_pc     (w_pc)
  );
  // next state and register-load strobes; a redirect always reloads the pc
  always_comb begin
    w_next      = r_state;
    w_addr_load = 1'b0;
    w_inst_load = 1'b0;
    w_inst_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        w_next      = bus.en ? FETCH : IDLE;
        w_addr_load = bus.en;
      end
      FETCH: begin
        w_inst_load = bus.imem_ack && !bus.redirect_valid;
        w_addr_load = bus.imem_ack && bus.redirect_valid;
        w_next      = w_inst_load ? VALID : (!bus.imem_ack && bus.redirect_valid) ? FLUSH : FETCH;
      end
      FLUSH: begin
        w_next      = bus.imem_ack ? FETCH : FLUSH;
        w_addr_load = bus.imem_ack;
      end
      VALID: begin
        w_inst_clr  = bus.redirect_valid || bus.inst_ready;
        w_next      = !w_inst_clr ? VALID : bus.en ? FETCH : IDLE;
        w_addr_load = w_inst_clr && bus.en;
      end
    endcase
  end
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // fetch address, held while a request is outstanding
  always_ff @(posedge clk)
    r_addr <= rst ? RESET_PC : w_addr_load ? w_addr_d : r_addr;
  // instruction register, NOP whenever nothing live is held
  always_ff @(posedge clk)
    r_inst <= (rst || w_inst_clr) ? NOP_INST : w_inst_load ? bus.imem_rdata : r_inst;
  assign bus.imem_req   = r_state == FETCH || r_state == FLUSH;
  assign bus.imem_addr  = r_addr;
  assign bus.inst       = r_inst;
  assign bus.inst_valid = r_state == VALID;
  assign bus.inst_pc    = w_pc;
  assign bus.pc_plus4   = w_pc + 32'd4;
endmodule

// File: tb/tb_t03_fetch.sv
// tb_t03_fetch: directed scenarios checked against a transaction-level fetch model
module tb_t03_fetch;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  t03_fetch_if bus ();
  t03_fetch dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] m_pc, m_addr, m_inst, tgt;
  logic        m_busy, m_stale, m_have;
  logic        m_init = 1'b0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // model: one outstanding request (busy), maybe stale, plus one held instruction
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0; m_addr = 32'h0; m_busy = 0; m_stale = 0; m_have = 0; m_inst = NOP; m_init = 1;
    end else begin
      tgt = {bus.redirect_target[31:2], 2'b00};
      if (m_have) begin
        if (bus.redirect_valid || bus.inst_ready) begin
          m_have = 0;
          m_inst = NOP;
          m_pc = bus.redirect_valid ? tgt : m_pc + 32'd4;
          if (bus.en) begin m_busy = 1; m_addr = m_pc; end
        end
      end else if (m_busy) begin
        if (bus.imem_ack) begin
          if (!m_stale && !bus.redirect_valid) begin
            m_inst = bus.imem_rdata; m_have = 1; m_busy = 0;
          end else begin
            m_stale = 0;
            if (bus.redirect_valid) m_pc = tgt;
            m_addr = m_pc;
          end
        end else if (bus.redirect_valid) begin
          m_pc = tgt; m_stale = 1;
        end
      end else begin
        if (bus.redirect_valid) m_pc = tgt;
        if (bus.en) begin m_busy = 1; m_addr = m_pc; end
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) if (m_init) begin
    chk("m_req",   {31'b0, bus.imem_req},   {31'b0, m_busy});
    chk("m_addr",  bus.imem_addr,           m_addr);
    chk("m_valid", {31'b0, bus.inst_valid}, {31'b0, m_have});
    chk("m_inst",  bus.inst,                m_have ? m_inst : NOP);
    chk("m_pc",    bus.inst_pc,             m_pc);
    chk("m_pc4",   bus.pc_plus4,            m_pc + 32'd4);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1; bus.en = 0; bus.imem_ack = 0; bus.imem_rdata = 0;
    bus.redirect_valid = 0; bus.redirect_target = 0; bus.inst_ready = 0;
    tick(); tick();
    chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst, 32'h13);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    // 1: first fetch
    rst = 0; bus.en = 1; tick();
    chk("t1_req", {31'b0, bus.imem_req}, 32'd1);
    chk("t1_addr", bus.imem_addr, 32'h0);
    bus.imem_ack = 1; bus.imem_rdata = 32'h0050_0093; bus.inst_ready = 1; tick();
    bus.imem_ack = 0;
    chk("t1_valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("t1_inst", bus.inst, 32'h0050_0093);
    chk("t1_pc4", bus.pc_plus4, 32'h4);
    tick();
    chk("t1_next_addr", bus.imem_addr, 32'h4);
    // 2: stall in VALID
    bus.inst_ready = 0; bus.imem_ack = 1; bus.imem_rdata = 32'h00a0_0113; tick();
    bus.imem_ack = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_inst", bus.inst, 32'h00a0_0113);
      chk("t2_pc", bus.inst_pc, 32'h4);
      chk("t2_req", {31'b0, bus.imem_req}, 32'd0);
    end
    bus.inst_ready = 1; tick();
    bus.inst_ready = 0;
    chk("t2_pc8", bus.inst_pc, 32'h8);
    // 3: redirect while request outstanding
    bus.redirect_valid = 1; bus.redirect_target = 32'h100; tick();
    bus.redirect_valid = 0;
    chk("t3_addr_held", bus.imem_addr, 32'h8);
    chk("t3_pc", bus.inst_pc, 32'h100);
    tick(); tick();
    bus.imem_ack = 1; bus.imem_rdata = 32'hDEAD_BEEF; tick();
    bus.imem_ack = 0;
    chk("t3_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("t3_addr", bus.imem_addr, 32'h100);
    tick();
    chk("t3_still_invalid", {31'b0, bus.inst_valid}, 32'd0);
    // 4: redirect beats ready in VALID
    bus.imem_ack = 1; bus.imem_rdata = 32'h0000_0073; tick();
    bus.imem_ack = 0;
    chk("t4_valid", {31'b0, bus.inst_valid}, 32'd1);
    bus.redirect_valid = 1; bus.redirect_target = 32'h202; bus.inst_ready = 1; tick();
    bus.redirect_valid = 0; bus.inst_ready = 0;
    chk("t4_pc", bus.inst_pc, 32'h200);
    chk("t4_inst", bus.inst, 32'h13);
    chk("t4_addr", bus.imem_addr, 32'h200);
    // 5: en dropped mid-fetch
    bus.en = 0; tick();
    chk("t5_req", {31'b0, bus.imem_req}, 32'd1);
    bus.imem_ack = 1; bus.imem_rdata = 32'h1234_5678; tick();
    bus.imem_ack = 0;
    chk("t5_inst", bus.inst, 32'h1234_5678);
    bus.inst_ready = 1; tick();
    bus.inst_ready = 0;
    chk("t5_idle_req", {31'b0, bus.imem_req}, 32'd0);
    chk("t5_pc", bus.inst_pc, 32'h204);
    tick();
    chk("t5_stay_idle", {31'b0, bus.imem_req}, 32'd0);
    // 6: wrap and reset with request in flight
    bus.redirect_valid = 1; bus.redirect_target = 32'hFFFF_FFFF; tick();
    bus.redirect_valid = 0;
    chk("t6_pc", bus.inst_pc, 32'hFFFF_FFFC);
    chk("t6_wrap", bus.pc_plus4, 32'h0);
    bus.en = 1; tick();
    chk("t6_addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.en = 0; rst = 1; tick();
    rst = 0;
    chk("t6_rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("t6_rst_addr", bus.imem_addr, 32'h0);
    bus.imem_ack = 1; bus.imem_rdata = 32'h0000_0BAD; tick();
    bus.imem_ack = 0;
    chk("t6_late_ack", {31'b0, bus.inst_valid}, 32'd0);
    chk("t6_inst", bus.inst, 32'h13);
    chk("t6_pc4", bus.pc_plus4, 32'h4);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
